glyph_sprite_scheduler: RTL
===========================

Name: glyph_sprite_scheduler

Overview:
- Shares one glyph ROM and colour-map path among NUM_SLOTS on-screen sprite slots, e.g. score digits and small icons.
- For every pixel it picks the winning slot covering (hcount_in, vcount_in) and issues the ROM address for that slot. It realigns the ROM data into a greyscale pixel.
- Slot position, glyph and enable are written through a valid/ready config port into shadow registers. Shadow registers commit to the active set only at the start of vertical blank, so sprites never tear mid-frame.
- Sits between the VGA timing generator and the pixel mixer.

Parameters:
- NUM_SLOTS, 4: number of sprite slots; slot index width is 2.
- WIDTH, 16: glyph width in pixels.
- HEIGHT, 16: glyph height in pixels.
- V_ACTIVE, 768: first vcount value of vertical blank; this is the commit line.
- ROM_LATENCY, 2: cycles from rom_addr_out to matching rom_data_in (ROM read plus colour-map read).

Ports:
- pixel_clk_in  in  1  pixel clock, sole clock.
- rst_in  in  1  synchronous, active-high reset.
- hcount_in  in  11  current horizontal pixel count.
- vcount_in  in  10  current vertical line count.
- cfg_valid_in  in  1  config write request.
- cfg_ready_out  out  1  config write accepted when high with cfg_valid_in.
- cfg_slot_in  in  2  slot being written.
- cfg_x_in  in  11  sprite left edge.
- cfg_y_in  in  10  sprite top edge.
- cfg_glyph_in  in  4  glyph index, 0..15.
- cfg_en_in  in  1  slot enable.
- rom_addr_out  out  16  glyph ROM address.
- rom_data_in  in  8  colour-mapped intensity for rom_addr_out, arriving ROM_LATENCY cycles later.
- pixel_out  out  12  greyscale pixel {d[7:4],d[7:4],d[7:4]}, or 0 when no hit.
- hit_out  out  1  pixel_out is sprite data.
- slot_out  out  2  winning slot, valid when hit_out=1.
- commit_out  out  1  one-cycle pulse when shadow copies to active.

Behaviour:
- Reset:
  - All shadow and active slots: en=0, x=0, y=0, glyph=0.
  - rom_addr_out=0, pixel_out=0, hit_out=0, slot_out=0, commit_out=0.
  - Pipeline valid bits are cleared; cfg_ready_out=1 on the first cycle after reset.
  - Reset mid-frame discards any pending shadow writes.
- Hit test (combinational on stage-0 inputs), for each active slot s:
  - en=1, x<=hcount<x+WIDTH, and y<=vcount<y+HEIGHT.
  - Sums are computed at 12/11 bits so that x+WIDTH > 2047 does not wrap. Sprites overhanging the right or bottom edge clip, with no false hit at low hcount.
- Priority: the lowest slot index wins on overlap. There is no transparency fallback: a winning slot whose data is 0 yields pixel_out=0 with hit_out=1.
- Stage 1 (registered, 1 cycle after hcount/vcount):
  - rom_addr_out = glyph*WIDTH*HEIGHT + (vcount-y)*WIDTH + (hcount-x), using the winning slot.
  - On no hit, rom_addr_out holds 0. hit/slot are registered alongside.
- Delay line: hit/slot are delayed ROM_LATENCY cycles to align with rom_data_in.
- Output stage (registered):
  - pixel_out = aligned hit ? {d[7:4],d[7:4],d[7:4]} : 0.
  - hit_out and slot_out follow.
  - Total latency from hcount/vcount to pixel_out is 2+ROM_LATENCY (4 by default), fixed and independent of hit.
- Config port:
  - A write occurs when cfg_valid_in & cfg_ready_out, updating shadow[cfg_slot_in] on the next edge.
  - cfg_ready_out=0 only on the commit cycle; otherwise 1.
  - The requester holds its fields while valid & !ready.
  - Back-to-back writes to the same slot: the last one wins.
- Commit:
  - Occurs on the cycle where vcount_in==V_ACTIVE && hcount_in==0: active <= shadow for all slots, and commit_out pulses for that single cycle.
  - Any write presented that cycle is stalled one cycle. It lands in shadow and takes effect on the next frame's commit.
  - Held hcount/vcount at the commit point does not re-pulse commit_out; the condition is edge-detected on entry.
- Writes never alter active registers directly, so the display is unaffected until commit.

Test Plan:
- Reset, then write slot0 {x=100,y=50,glyph=3,en=1}; run to vcount=768,hcount=0 -> commit_out pulses once. Next frame at (100,50): rom_addr_out=768 one cycle later. With rom_data_in=0xA0, pixel_out=0xAAA and hit_out=1 four cycles after the input.
- Same sprite, pixel (115,65) -> addr=768+15*16+15=1023, hit. Pixel (116,65) and (99,50) -> hit_out=0, pixel_out=0.
- Slot0 at (200,200) glyph 1 and slot2 at (208,200) glyph 5; pixel (210,205) -> slot_out=0, addr=256+5*16+10=346.
- Write slot1 x=2040 -> hit at hcount 2040..2047 only. No hit at hcount 0..7 on the same lines (no wrap).
- Hold cfg_valid_in=1 across the commit cycle -> cfg_ready_out=0 for exactly that cycle. The write is absent from the current active set and appears after the following commit.
- Write slot0 mid-frame at vcount=300 -> pixel output for rows 300..767 unchanged; the new values appear only after commit. Assert rst_in mid-frame -> all outputs 0 on the next cycle and no sprites displayed.

Source files
------------

// File: rtl/glyph_sprite_scheduler.sv
// Per-pixel sprite arbiter sharing one glyph ROM among NUM_SLOTS slots, with
// frame-synchronous shadow->active commit at the start of vertical blank.
module glyph_sprite_scheduler #(
    parameter int NUM_SLOTS   = 4,
    parameter int WIDTH       = 16,
    parameter int HEIGHT      = 16,
    parameter int V_ACTIVE    = 768,
    parameter int ROM_LATENCY = 2
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        cfg_valid_in,
    output logic        cfg_ready_out,
    input  logic [1:0]  cfg_slot_in,
    input  logic [10:0] cfg_x_in,
    input  logic [9:0]  cfg_y_in,
    input  logic [3:0]  cfg_glyph_in,
    input  logic        cfg_en_in,
    output logic [15:0] rom_addr_out,
    input  logic [7:0]  rom_data_in,
    output logic [11:0] pixel_out,
    output logic        hit_out,
    output logic [1:0]  slot_out,
    output logic        commit_out
);

    logic [10:0] sh_x     [NUM_SLOTS];
    logic [9:0]  sh_y     [NUM_SLOTS];
    logic [3:0]  sh_glyph [NUM_SLOTS];
    logic        sh_en    [NUM_SLOTS];
    logic [10:0] act_x     [NUM_SLOTS];
    logic [9:0]  act_y     [NUM_SLOTS];
    logic [3:0]  act_glyph [NUM_SLOTS];
    logic        act_en    [NUM_SLOTS];

    logic        at_point;
    logic        at_point_q;
    logic        commit_now;
    logic        cfg_fire;

    logic [NUM_SLOTS-1:0] in_box;
    logic [15:0]          slot_addr [NUM_SLOTS];
    logic                 win_hit;
    logic [1:0]           win_slot;
    logic [15:0]          win_addr;

    logic        hit_s1;
    logic [1:0]  slot_s1;
    logic        hit_dly  [ROM_LATENCY];
    logic [1:0]  slot_dly [ROM_LATENCY];
    logic        unused_rom_low;

    // Commit fires only on entry to the commit point, so a stalled raster does not re-commit.
    assign at_point      = (vcount_in == 10'(V_ACTIVE)) && (hcount_in == 11'd0);
    assign commit_now    = at_point && !at_point_q && !rst_in;
    assign commit_out    = commit_now;
    assign cfg_ready_out = !commit_now;
    assign cfg_fire      = cfg_valid_in && cfg_ready_out;
    assign unused_rom_low = ^rom_data_in[3:0];

    // End coordinates carry one extra bit so sprites at the right/bottom edge clip instead of wrapping.
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
        logic [11:0] x_end;
        logic [10:0] y_end;
        assign x_end = {1'b0, act_x[g]} + 12'(WIDTH);
        assign y_end = {1'b0, act_y[g]} + 11'(HEIGHT);
        assign in_box[g] = act_en[g]
                           && (hcount_in >= act_x[g]) && ({1'b0, hcount_in} < x_end)
                           && (vcount_in >= act_y[g]) && ({1'b0, vcount_in} < y_end);
        assign slot_addr[g] = 16'(act_glyph[g]) * 16'(WIDTH * HEIGHT)
                              + 16'(vcount_in - act_y[g]) * 16'(WIDTH)
                              + 16'(hcount_in - act_x[g]);
    end

    always_comb begin
        win_hit  = 1'b0;
        win_slot = 2'd0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (in_box[s]) begin
                win_hit  = 1'b1;
                win_slot = 2'(s);
            end
        end
        win_addr = slot_addr[win_slot];
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                sh_x[s]      <= '0;
                sh_y[s]      <= '0;
                sh_glyph[s]  <= '0;
                sh_en[s]     <= 1'b0;
                act_x[s]     <= '0;
                act_y[s]     <= '0;
                act_glyph[s] <= '0;
                act_en[s]    <= 1'b0;
            end
            at_point_q   <= 1'b0;
            rom_addr_out <= '0;
            hit_s1       <= 1'b0;
            slot_s1      <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                hit_dly[i]  <= 1'b0;
                slot_dly[i] <= '0;
            end
            pixel_out <= '0;
            hit_out   <= 1'b0;
            slot_out  <= '0;
        end else begin
            at_point_q <= at_point;
            if (commit_now) begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    act_x[s]     <= sh_x[s];
                    act_y[s]     <= sh_y[s];
                    act_glyph[s] <= sh_glyph[s];
                    act_en[s]    <= sh_en[s];
                end
            end
            if (cfg_fire) begin
                sh_x[cfg_slot_in]     <= cfg_x_in;
                sh_y[cfg_slot_in]     <= cfg_y_in;
                sh_glyph[cfg_slot_in] <= cfg_glyph_in;
                sh_en[cfg_slot_in]    <= cfg_en_in;
            end

            rom_addr_out <= win_hit ? win_addr : 16'd0;
            hit_s1       <= win_hit;
            slot_s1      <= win_slot;

            // Hit/slot travel alongside the ROM read so they meet rom_data_in.
            hit_dly[0]  <= hit_s1;
            slot_dly[0] <= slot_s1;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                hit_dly[i]  <= hit_dly[i-1];
                slot_dly[i] <= slot_dly[i-1];
            end

            pixel_out <= hit_dly[ROM_LATENCY-1]
                         ? {rom_data_in[7:4], rom_data_in[7:4], rom_data_in[7:4]} : 12'd0;
            hit_out   <= hit_dly[ROM_LATENCY-1];
            slot_out  <= slot_dly[ROM_LATENCY-1];
        end
    end

endmodule
